guess_game_core: RTL and testbench

Sequential controller for the switch-driven number-guessing game, generalised from the fixed 4-bit comparator to a parametrised width. It holds a pseudo-random secret, scores each submitted guess and registers the higher/lower/equal hints. It also counts attempts against a limit, narrows the known-valid range and declares win or loss. It sits between the debounced button/switch inputs and the LED/7-segment display logic.

---
 rtl/guess_game_pkg.sv | 21 ++
 rtl/lfsr16.sv | 30 +++
 rtl/guess_game_core.sv | 161 ++++++++++++++++
 tb/tb_guess_game_core.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/guess_game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : guess_game_pkg
// Purpose  : Shared types and constants for the number-guessing game core.
// Revision : 1.0 - initial release
// ============================================================================
package guess_game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WIN  = 2'd2,
        LOSE = 2'd3
    } game_state_t;

    // Feedback taps at bits 15, 13, 12 and 10 (x^16 + x^14 + x^13 + x^11 + 1)
    localparam logic [15:0] C_LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] C_DEFAULT_SEED = 16'hACE1;

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : lfsr16
// Purpose  : Free-running 16-bit Fibonacci LFSR, left-shifting, seeded on reset.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr16
    import guess_game_pkg::*;
#(
    parameter logic [15:0] SEED = C_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & C_LFSR_TAPS)};
        end
    end

    assign lfsr = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/guess_game_core.sv
`default_nettype none
// ============================================================================
// Module   : guess_game_core
// Purpose  : Number-guessing game controller: secret, hints, range and tries.
// Revision : 1.0 - initial release
// ============================================================================
module guess_game_core
    import guess_game_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter int          MAX_TRIES = 5,
    parameter logic [15:0] SEED      = C_DEFAULT_SEED
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WIDTH-1:0]               guess,
    input  logic                           submit,
    input  logic                           new_game,
    output logic                           is_equal,
    output logic                           is_greater,
    output logic                           is_less,
    output logic                           hint_valid,
    output logic                           wasted,
    output logic [WIDTH-1:0]               lo_bound,
    output logic [WIDTH-1:0]               hi_bound,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_used,
    output logic                           playing,
    output logic                           win,
    output logic                           lose,
    output logic [WIDTH-1:0]               reveal
);

    localparam int TW = $clog2(MAX_TRIES + 1);

    game_state_t      r_state;
    game_state_t      w_state_next;
    logic [15:0]      w_lfsr;
    logic [WIDTH-1:0] r_secret;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [TW-1:0]    r_tries;
    logic             r_eq;
    logic             r_gt;
    logic             r_lt;
    logic             r_valid;
    logic             r_wasted;

    logic             w_eq;
    logic             w_gt;
    logic             w_lt;
    logic             w_score;
    logic             w_last_try;
    logic             w_wasted;
    logic [WIDTH-1:0] w_guess_dec;
    logic [WIDTH-1:0] w_guess_inc;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (w_lfsr)
    );

    generate
        if (WIDTH < 16) begin : g_unused_lfsr
            logic w_unused_lfsr;
            assign w_unused_lfsr = ^w_lfsr[15:WIDTH];
        end
    endgenerate

    assign w_eq        = (guess == r_secret);
    assign w_gt        = (guess >  r_secret);
    assign w_lt        = (guess <  r_secret);
    // new_game takes priority, so a coincident submit is never scored
    assign w_score     = submit && !new_game && (r_state == PLAY);
    assign w_last_try  = ((int'(r_tries) + 1) == MAX_TRIES);
    assign w_wasted    = (guess < r_lo) || (guess > r_hi);
    assign w_guess_dec = guess - WIDTH'(1);
    assign w_guess_inc = guess + WIDTH'(1);

    always_comb begin
        w_state_next = r_state;
        if (new_game) begin
            w_state_next = PLAY;
        end else if (w_score) begin
            if (w_eq) begin
                w_state_next = WIN;
            end else if (w_last_try) begin
                w_state_next = LOSE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_secret <= '0;
            r_lo     <= '0;
            r_hi     <= '1;
            r_tries  <= '0;
            r_eq     <= 1'b0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
            r_valid  <= 1'b0;
            r_wasted <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (new_game) begin
                r_secret <= w_lfsr[WIDTH-1:0];
                r_lo     <= '0;
                r_hi     <= '1;
                r_tries  <= '0;
                r_eq     <= 1'b0;
                r_gt     <= 1'b0;
                r_lt     <= 1'b0;
                r_wasted <= 1'b0;
            end else if (w_score) begin
                r_eq     <= w_eq;
                r_gt     <= w_gt;
                r_lt     <= w_lt;
                r_valid  <= 1'b1;
                r_wasted <= w_wasted;
                r_tries  <= r_tries + TW'(1);
                // guess-1 / guess+1 cannot wrap on the branch that uses them
                if (w_eq) begin
                    r_lo <= guess;
                    r_hi <= guess;
                end else if (w_gt) begin
                    if (w_guess_dec < r_hi) begin
                        r_hi <= w_guess_dec;
                    end
                end else if (w_guess_inc > r_lo) begin
                    r_lo <= w_guess_inc;
                end
            end
        end
    end

    assign is_equal   = r_eq;
    assign is_greater = r_gt;
    assign is_less    = r_lt;
    assign hint_valid = r_valid;
    assign wasted     = r_wasted;
    assign lo_bound   = r_lo;
    assign hi_bound   = r_hi;
    assign tries_used = r_tries;
    assign playing    = (r_state == PLAY);
    assign win        = (r_state == WIN);
    assign lose       = (r_state == LOSE);
    assign reveal     = (win || lose) ? r_secret : '0;

endmodule
`default_nettype wire

// File: tb/tb_guess_game_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_guess_game_core
// Purpose  : Scoreboard bench for guess_game_core (WIDTH=4, MAX_TRIES=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_guess_game_core;

    logic       clk;
    logic       rst;
    logic [3:0] guess;
    logic       submit;
    logic       new_game;
    logic       is_equal;
    logic       is_greater;
    logic       is_less;
    logic       hint_valid;
    logic       wasted;
    logic [3:0] lo_bound;
    logic [3:0] hi_bound;
    logic [1:0] tries_used;
    logic       playing;
    logic       win;
    logic       lose;
    logic [3:0] reveal;

    guess_game_core #(
        .WIDTH     (4),
        .MAX_TRIES (3),
        .SEED      (16'hACE1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .guess      (guess),
        .submit     (submit),
        .new_game   (new_game),
        .is_equal   (is_equal),
        .is_greater (is_greater),
        .is_less    (is_less),
        .hint_valid (hint_valid),
        .wasted     (wasted),
        .lo_bound   (lo_bound),
        .hi_bound   (hi_bound),
        .tries_used (tries_used),
        .playing    (playing),
        .win        (win),
        .lose       (lose),
        .reveal     (reveal)
    );

    typedef struct packed {
        logic       eq;
        logic       gt;
        logic       lt;
        logic       wasted;
        logic [3:0] lo;
        logic [3:0] hi;
        logic [1:0] tries;
        logic       playing;
        logic       win;
        logic       lose;
        logic [3:0] reveal;
    } hint_t;

    hint_t       sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] m_lfsr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference LFSR tracking the DUT from reset
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic hint_t sample_dut();
        hint_t h;
        h = '{is_equal, is_greater, is_less, wasted, lo_bound, hi_bound,
              tries_used, playing, win, lose, reveal};
        return h;
    endfunction

    always @(negedge clk) begin
        if (hint_valid) begin
            hint_t act;
            hint_t exp;
            act = sample_dut();
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_hint_valid: got %h, required no hint", act);
            end else begin
                exp = sb_q.pop_front();
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL hint_vector: got %h, required %h (eq gt lt wasted lo hi tries playing win lose reveal)",
                             act, exp);
                end
            end
        end
    end

    task automatic sb_push(input logic eq, input logic gt, input logic lt, input logic wst,
                           input logic [3:0] lo, input logic [3:0] hi, input logic [1:0] tr,
                           input logic pl, input logic wn, input logic ls, input logic [3:0] rv);
        hint_t h;
        h = '{eq, gt, lt, wst, lo, hi, tr, pl, wn, ls, rv};
        sb_q.push_back(h);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_flags"}, 32'({is_equal, is_greater, is_less, hint_valid, wasted, win, lose, playing}), 32'h0);
        chk({tag, "_lo"}, 32'(lo_bound), 32'h0);
        chk({tag, "_hi"}, 32'(hi_bound), 32'hF);
        chk({tag, "_tries"}, 32'(tries_used), 32'h0);
        chk({tag, "_reveal"}, 32'(reveal), 32'h0);
    endtask

    // playing, win, lose, hint_valid, eq, gt, lt, wasted, lo, hi, tries, reveal
    task automatic check_fresh(input string tag);
        chk(tag, 32'({playing, win, lose, hint_valid, is_equal, is_greater, is_less, wasted,
                      lo_bound, hi_bound, tries_used, reveal}),
            32'({1'b1, 7'b0, 4'h0, 4'hF, 2'd0, 4'h0}));
    endtask

    task automatic wait_secret(input logic [3:0] s);
        int n;
        n = 0;
        while (m_lfsr[3:0] != s && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            n_vec++;
            n_err++;
            $display("FAIL lfsr_wait: got no nibble match, required %h", s);
        end
    endtask

    task automatic start_game(input logic [3:0] s, input string tag);
        wait_secret(s);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        check_fresh(tag);
    endtask

    task automatic do_submit(input logic [3:0] g);
        guess  = g;
        submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        guess    = 4'h0;
        submit   = 1'b0;
        new_game = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        // S=9: narrowing from both sides, then a win on the last try
        start_game(4'd9, "ng_s9");
        sb_push(0, 0, 1, 0, 4'd5, 4'd15, 2'd1, 1, 0, 0, 4'd0);
        do_submit(4'd4);
        sb_push(0, 1, 0, 0, 4'd5, 4'd11, 2'd2, 1, 0, 0, 4'd0);
        do_submit(4'd12);
        sb_push(1, 0, 0, 0, 4'd9, 4'd9, 2'd3, 0, 1, 0, 4'd9);
        do_submit(4'd9);

        // S=6: wasted repeat guess, loss, ignored submit afterwards
        start_game(4'd6, "ng_s6");
        sb_push(0, 0, 1, 0, 4'd1, 4'd15, 2'd1, 1, 0, 0, 4'd0);
        do_submit(4'd0);
        sb_push(0, 0, 1, 1, 4'd1, 4'd15, 2'd2, 1, 0, 0, 4'd0);
        do_submit(4'd0);
        sb_push(0, 0, 1, 0, 4'd3, 4'd15, 2'd3, 0, 0, 1, 4'd6);
        do_submit(4'd2);
        do_submit(4'd6);
        chk("ignored_tries", 32'(tries_used), 32'd3);
        chk("ignored_lose", 32'({lose, reveal}), 32'({1'b1, 4'd6}));

        // new_game with a coincident submit mid-game; next secret 15
        start_game(4'd3, "ng_s3");
        sb_push(0, 0, 1, 0, 4'd2, 4'd15, 2'd1, 1, 0, 0, 4'd0);
        do_submit(4'd1);
        wait_secret(4'd15);
        guess    = 4'd15;
        submit   = 1'b1;
        new_game = 1'b1;
        @(negedge clk);
        submit   = 1'b0;
        new_game = 1'b0;
        check_fresh("ng_collide");
        sb_push(1, 0, 0, 0, 4'd15, 4'd15, 2'd1, 0, 1, 0, 4'd15);
        do_submit(4'd15);

        // S=0 first-try win, then S=15 loss with bottom-end guesses
        start_game(4'd0, "ng_s0");
        sb_push(1, 0, 0, 0, 4'd0, 4'd0, 2'd1, 0, 1, 0, 4'd0);
        do_submit(4'd0);
        chk("win_s0", 32'(win), 32'd1);
        start_game(4'd15, "ng_s15");
        sb_push(0, 0, 1, 0, 4'd1, 4'd15, 2'd1, 1, 0, 0, 4'd0);
        do_submit(4'd0);
        sb_push(0, 0, 1, 1, 4'd1, 4'd15, 2'd2, 1, 0, 0, 4'd0);
        do_submit(4'd0);
        sb_push(0, 0, 1, 1, 4'd1, 4'd15, 2'd3, 0, 0, 1, 4'd15);
        do_submit(4'd0);

        // rst mid-PLAY with a concurrent submit; LFSR must restart at SEED
        start_game(4'd5, "ng_s5");
        rst    = 1'b1;
        guess  = 4'd2;
        submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        check_reset_state("mid_rst");
        rst      = 1'b0;
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        check_fresh("ng_after_rst");
        // SEED 16'hACE1 gives a first secret of 4'h1
        sb_push(1, 0, 0, 0, 4'd1, 4'd1, 2'd1, 0, 1, 0, 4'd1);
        do_submit(4'd1);

        repeat (2) @(negedge clk);
        while (sb_q.size() != 0) begin
            hint_t lost;
            lost = sb_q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missing_hint: got no hint_valid, required %h", lost);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
